// File: rtl/alu_pkg.sv
// Opcode map, FSM encoding and opcode-class predicates shared by the
// multi-cycle ALU and its iterative datapath.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_MUL   = 4'd2;
  localparam logic [3:0] ALU_DIVU  = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_OR    = 4'd5;
  localparam logic [3:0] ALU_XOR   = 4'd6;
  localparam logic [3:0] ALU_GEU   = 4'd7;
  localparam logic [3:0] ALU_LTU   = 4'd8;
  localparam logic [3:0] ALU_EQ    = 4'd9;
  localparam logic [3:0] ALU_NE    = 4'd10;
  localparam logic [3:0] ALU_DIV   = 4'd11;
  localparam logic [3:0] ALU_REMU  = 4'd12;
  localparam logic [3:0] ALU_REM   = 4'd13;
  localparam logic [3:0] ALU_LT    = 4'd14;
  localparam logic [3:0] ALU_MULHU = 4'd15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_div(input logic [3:0] op);
    return (op == ALU_DIVU) || (op == ALU_DIV) || (op == ALU_REMU) || (op == ALU_REM);
  endfunction

  function automatic logic is_iter(input logic [3:0] op);
    return is_div(op) || (op == ALU_MUL) || (op == ALU_MULHU);
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Bit-serial unsigned multiply (shift-add) and restoring divide; one step per
// clock. hi/lo hold {product} for multiply and {remainder, quotient} for divide.
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int N  = 64,
  parameter int CW = $clog2(N) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           start,
  input  logic [3:0]     op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [N-1:0]   quo,
  output logic [N-1:0]   rem,
  output logic [2*N-1:0] prod
);

  logic [N-1:0]  hi, lo, bq;
  logic [CW-1:0] cnt;
  logic          div_q;
  logic [N:0]    mul_sum, trial, diff;
  logic          fits;

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, bq} : {(N+1){1'b0}});
    trial   = {hi, lo[N-1]};
    diff    = trial - {1'b0, bq};
    fits    = (trial >= {1'b0, bq});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      bq    <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
      done  <= 1'b0;
    end else if (flush) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      hi    <= '0;
      lo    <= a;
      bq    <= b;
      div_q <= is_div(op);
      cnt   <= CW'(N);
      done  <= 1'b0;
    end else if (cnt != '0) begin
      // multiplier bits leave lo from the bottom; dividend bits from the top
      if (div_q) begin
        hi <= fits ? diff[N-1:0] : trial[N-1:0];
        lo <= {lo[N-2:0], fits};
      end else begin
        hi <= mul_sum[N:1];
        lo <= {mul_sum[0], lo[N-1:1]};
      end
      cnt  <= cnt - CW'(1);
      done <= (cnt == CW'(1));
    end else begin
      done <= 1'b0;
    end
  end

  assign quo  = lo;
  assign rem  = hi;
  assign prod = {hi, lo};

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU with valid/ready on both sides: single-cycle ops and
// divide special cases finish at the accept edge, mul/div take N+1 edges.
module alu_mc
  import alu_pkg::*;
#(
  parameter  int N  = 64,
  localparam int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res,
  output logic         busy
);

  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  function automatic logic [N-1:0] alu_single(input logic [3:0] op,
                                               input logic [N-1:0] x, y);
    logic [N-1:0] r;
    r = '0;
    case (op)
      ALU_ADD: r = x + y;
      ALU_SUB: r = x - y;
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_XOR: r = x ^ y;
      ALU_GEU: r = {{(N-1){1'b0}}, x >= y};
      ALU_LTU: r = {{(N-1){1'b0}}, x < y};
      ALU_EQ:  r = {{(N-1){1'b0}}, x == y};
      ALU_NE:  r = {{(N-1){1'b0}}, x != y};
      ALU_LT:  r = {{(N-1){1'b0}}, $signed(x) < $signed(y)};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [N-1:0] sign_fix(input logic [N-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic [1:0]     state;
  logic [3:0]     op_q;
  logic           neg_q;
  logic           accept, sgn_op, a_neg, b_neg, b_zero, ovf, special, neg_d, core_start;
  logic [N-1:0]   abs_a, abs_b, special_res, iter_res;
  logic           core_done;
  logic [N-1:0]   core_quo, core_rem;
  logic [2*N-1:0] core_prod;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid & in_ready & ~flush;

  // Signed divides run on magnitudes; the sign is restored when res is loaded.
  always_comb begin
    sgn_op      = (sel == ALU_DIV) || (sel == ALU_REM);
    a_neg       = sgn_op & a[N-1];
    b_neg       = sgn_op & b[N-1];
    abs_a       = a_neg ? -a : a;
    abs_b       = b_neg ? -b : b;
    b_zero      = (b == '0);
    ovf         = sgn_op && (a == MIN_VAL) && (b == '1);
    special     = is_div(sel) && (b_zero || ovf);
    neg_d       = (sel == ALU_DIV) ? (a_neg ^ b_neg) : a_neg;
    core_start  = accept && is_iter(sel) && !special;
    special_res = '0;
    if (b_zero)
      special_res = ((sel == ALU_DIV) || (sel == ALU_DIVU)) ? '1 : a;
    else if (sel == ALU_DIV)
      special_res = MIN_VAL;
  end

  always_comb begin
    iter_res = '0;
    case (op_q)
      ALU_MUL:            iter_res = core_prod[N-1:0];
      ALU_MULHU:          iter_res = core_prod[2*N-1:N];
      ALU_DIV, ALU_DIVU:  iter_res = sign_fix(core_quo, neg_q);
      ALU_REM, ALU_REMU:  iter_res = sign_fix(core_rem, neg_q);
      default:            iter_res = '0;
    endcase
  end

  alu_iter_core #(.N(N), .CW(CW)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .start (core_start),
    .op    (sel),
    .a     (abs_a),
    .b     (abs_b),
    .done  (core_done),
    .quo   (core_quo),
    .rem   (core_rem),
    .prod  (core_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      res   <= '0;
      op_q  <= ALU_ADD;
      neg_q <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          op_q  <= sel;
          neg_q <= sgn_op & neg_d;
          if (special) begin
            res   <= special_res;
            state <= ST_DONE;
          end else if (is_iter(sel)) begin
            state <= ST_BUSY;
          end else begin
            res   <= alu_single(sel, a, b);
            state <= ST_DONE;
          end
        end
        ST_BUSY: if (core_done) begin
          res   <= iter_res;
          state <= ST_DONE;
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Randomised scoreboard bench for alu_mc: a driver pushes expected results,
// a monitor pops and checks value, latency, stability and in_ready on output.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int N = 64;
  localparam logic [N-1:0] MINV = 64'h8000_0000_0000_0000;

  logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic [3:0]   sel = '0;
  logic         in_ready, out_valid, busy;
  logic [N-1:0] res;

  always #5 clk = ~clk;

  alu_mc #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .busy(busy)
  );

  typedef struct {
    logic [N-1:0] exp;
    longint       lat;
    longint       acc;
    logic [3:0]   op;
  } item_t;

  item_t  sb[$];
  int     passed = 0, total = 0;
  longint edges = 0;
  int     bp_mode = 0;   // 0 random out_ready, 1 hold low, 2 hold high

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference behaviour straight from the opcode table.
  function automatic logic [N-1:0] model(input logic [3:0] op, input logic [N-1:0] x, y);
    logic [2*N-1:0] p;
    longint sx, sy;
    sx = x; sy = y;
    p  = {{N{1'b0}}, x} * {{N{1'b0}}, y};
    case (op)
      ALU_ADD:   return x + y;
      ALU_SUB:   return x - y;
      ALU_MUL:   return p[N-1:0];
      ALU_MULHU: return p[2*N-1:N];
      ALU_AND:   return x & y;
      ALU_OR:    return x | y;
      ALU_XOR:   return x ^ y;
      ALU_GEU:   return (x >= y) ? 1 : 0;
      ALU_LTU:   return (x < y) ? 1 : 0;
      ALU_EQ:    return (x == y) ? 1 : 0;
      ALU_NE:    return (x != y) ? 1 : 0;
      ALU_LT:    return (sx < sy) ? 1 : 0;
      ALU_DIVU:  return (y == 0) ? '1 : x / y;
      ALU_REMU:  return (y == 0) ? x : x % y;
      ALU_DIV: begin
        if (y == 0) return '1;
        if (x == MINV && sy == -1) return MINV;
        return sx / sy;
      end
      ALU_REM: begin
        if (y == 0) return x;
        if (x == MINV && sy == -1) return '0;
        return sx % sy;
      end
      default: return '0;
    endcase
  endfunction

  // Edges from the accept edge to the edge that raises out_valid.
  function automatic longint lat_of(input logic [3:0] op, input logic [N-1:0] x, y);
    longint sy;
    sy = y;
    if (op == ALU_MUL || op == ALU_MULHU) return N + 1;
    if (op == ALU_DIVU || op == ALU_REMU) return (y == 0) ? 0 : N + 1;
    if (op == ALU_DIV || op == ALU_REM)
      return (y == 0 || (x == MINV && sy == -1)) ? 0 : N + 1;
    return 0;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("wait_idle_timeout", {63'b0, in_ready}, 1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [N-1:0] x, y,
                       input logic [N-1:0] exp, input longint lat, input bit push);
    item_t it;
    wait_idle();
    sel = op; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sel = $urandom_range(0, 15);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    it.exp = exp; it.lat = lat; it.acc = edges; it.op = op;
    if (push) sb.push_back(it);
  endtask

  task automatic issue_rand(input logic [3:0] op, input logic [N-1:0] x, y);
    issue(op, x, y, model(op, x, y), lat_of(op, x, y), 1'b1);
  endtask

  // Monitor: checks the head of the scoreboard whenever out_valid is up.
  initial begin
    bit seen = 0, unstable = 0, bad_ready = 0;
    logic [N-1:0] held = '0;
    logic rdy;
    forever begin
      @(negedge clk);
      rdy = (bp_mode == 2) || (bp_mode == 0 && $urandom_range(0, 3) != 0);
      if (rst_n) begin
        if (busy && in_ready) bad_ready = 1;
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("stray_out_valid", {63'b0, out_valid}, 0);
            rdy = 1'b1;
          end else begin
            if (!seen) begin
              seen = 1;
              held = res;
              chk($sformatf("latency_op%0d", sb[0].op), N'(edges - sb[0].acc), N'(sb[0].lat));
            end else if (res !== held) begin
              unstable = 1;
            end
            if (rdy) begin
              chk($sformatf("res_op%0d", sb[0].op), res, sb[0].exp);
              chk("res_stable", {63'b0, unstable}, 0);
              chk("in_ready_low_while_busy", {63'b0, bad_ready}, 0);
              void'(sb.pop_front());
              seen = 0; unstable = 0; bad_ready = 0;
            end
          end
        end
      end
      out_ready = rdy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d items pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] op;
    logic [N-1:0] x, y;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_res", res, 0);
    chk("reset_out_valid", {63'b0, out_valid}, 0);
    chk("reset_busy", {63'b0, busy}, 0);
    chk("reset_in_ready", {63'b0, in_ready}, 1);
    rst_n = 1'b1;

    issue(ALU_ADD, '1, 1, 0, 0, 1);
    issue(ALU_LTU, 1, 2, 1, 0, 1);
    issue(ALU_LT, '1, 1, 1, 0, 1);
    issue(ALU_MUL, 64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001, 65, 1);
    issue(ALU_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1);
    issue(ALU_DIV, -64'sd7, 2, -64'sd3, 65, 1);
    issue(ALU_REM, -64'sd7, 2, -64'sd1, 65, 1);
    issue(ALU_DIVU, 100, 7, 14, 65, 1);
    issue(ALU_REMU, 100, 7, 2, 65, 1);
    issue(ALU_DIVU, 5, 0, '1, 0, 1);
    issue(ALU_REM, 5, 0, 5, 0, 1);
    issue(ALU_DIV, MINV, '1, MINV, 0, 1);
    issue(ALU_REM, MINV, '1, 0, 0, 1);

    // Backpressure: result must sit in DONE while out_ready is held low.
    wait_idle();
    bp_mode = 1;
    issue(ALU_XOR, 64'h0F0F, 64'h00FF, 64'h0FF0, 0, 1);
    repeat (10) @(negedge clk);
    chk("bp_out_valid", {63'b0, out_valid}, 1);
    chk("bp_in_ready", {63'b0, in_ready}, 0);
    bp_mode = 2;
    n = 0;
    while (out_valid && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("bp_release_in_ready", {63'b0, in_ready}, 1);
    bp_mode = 0;

    // Flush 20 steps into a multiply: nothing may come out.
    issue(ALU_MUL, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", {63'b0, in_ready}, 1);
    chk("flush_out_valid", {63'b0, out_valid}, 0);
    issue(ALU_ADD, 3, 4, 7, 0, 1);

    // Asynchronous reset in the middle of a divide.
    issue(ALU_DIVU, {$urandom, $urandom}, 12345, 0, 0, 0);
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("amid_rst_out_valid", {63'b0, out_valid}, 0);
    chk("amid_rst_res", res, 0);
    chk("amid_rst_busy", {63'b0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 15);
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: y = '0;
        1: begin x = MINV; y = '1; end
        2: begin x = $urandom_range(0, 200); y = $urandom_range(1, 20); end
        3: begin x = -$urandom_range(0, 200); y = $urandom_range(1, 20); end
        4: y = x;
        default: ;
      endcase
      issue_rand(op, x, y);
    end

    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", N'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle integer ALU; successor to the single-cycle combinational ALU in the npc execute stage.
- Single-cycle ops: add/sub/logic/compare. Iterative ops: multiply (high and low) and divide/remainder (signed and unsigned), one bit per cycle.
- Valid/ready handshake on both sides, so EXU can stall on long ops.
- Sits between IDU operand select and the EXU result/writeback register.

Parameters:
- N, 64, operand/result width; any value ≥ 4.
- CW, $clog2(N)+1, width of the iteration counter; derived, do not override.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous abort of any op in flight.
- in_valid, input, 1, request valid.
- in_ready, output, 1, high only in IDLE.
- a, input, N, operand A.
- b, input, N, operand B.
- sel, input, 4, opcode (encoding below).
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- res, output, N, result; held stable while out_valid is high.
- busy, output, 1, state is not IDLE.

Behaviour:
- Opcodes (4-bit):
  - 0 ADD; 1 SUB; 2 MUL (low N bits); 3 DIVU; 4 AND; 5 OR; 6 XOR.
  - 7 GEU (a>=b unsigned → 1 else 0); 8 LTU; 9 EQ; 10 NE.
  - 11 DIV (signed); 12 REMU; 13 REM (signed); 14 LT (signed); 15 MULHU (high N bits, unsigned).
  - Compare results are zero-extended to N.
  - Existing encodings 0–10 keep their single-cycle meanings, except MUL and DIVU are now iterative.
- Reset (rst_n low, async): state=IDLE, res=0, out_valid=0, busy=0, counter=0, in_ready=1 once reset is released.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Accept on in_valid & in_ready; operands and sel are captured on that edge.
  - Single-cycle op → DONE with res loaded; out_valid high in the cycle after the accept edge (latency 1).
  - Iterative op → BUSY, counter=N.
  - Signed ops latch |a|, |b| and the result sign.
- BUSY:
  - One step per edge; counter decrements.
  - MUL/MULHU: shift-add into a 2N accumulator.
  - DIV/DIVU/REM/REMU: restoring division.
  - On the edge where counter reaches 0: apply sign fix-up and load res → DONE.
  - out_valid rises N+1 edges after the accept edge.
- DONE:
  - out_valid=1 and res held stable.
  - On out_valid & out_ready → IDLE.
  - No accept in the same cycle; max throughput is 1 op per 2 cycles for single-cycle ops.
- Divide special cases (shortcut to DONE at the accept edge, latency 1):
  - b==0: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow (a==MIN, b==−1): DIV → MIN; REM → 0.
- Sign rules:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of a.
- Arithmetic: ADD/SUB wrap modulo 2^N; no flags.
- flush:
  - In any state, returns to IDLE on the next edge; out_valid=0; res unchanged.
  - flush outranks a simultaneous accept: in_ready stays 1 but nothing is captured.
- Output rules:
  - out_valid never drops without the out_valid & out_ready handshake, except on flush or reset.
  - Inputs are ignored outside IDLE.
- Async reset mid-BUSY: all state is cleared immediately; the partial result is discarded.

Decomposition:
- Package alu_pkg:
  - 4-bit opcode localparams (ALU_ADD … ALU_MULHU).
  - State encoding (IDLE/BUSY/DONE).
  - Helper predicate is_iter(sel).
- One sub-module, alu_iter_core:
  - Holds the shift-add / restoring-divide datapath (accumulator, partial remainder, counter).
  - Interface: start, op, operands in; done, quotient/remainder/product out.
- alu_mc contains the FSM, the single-cycle datapath, the special-case shortcuts and sign fix-up.

Test Plan:
- N=64, ADD a=0xFFFF_FFFF_FFFF_FFFF b=1 → res=0, out_valid the cycle after accept; LTU a=1 b=2 → res=1; LT a=−1 b=1 → res=1.
- MUL a=0x1_0000_0001 b=0x1_0000_0001 → res=0x2_0000_0001; MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → res=0xFFFF_FFFF_FFFF_FFFE; out_valid exactly 65 edges after the accept edge; in_ready=0 throughout.
- DIV a=−7 b=2 → −3; REM a=−7 b=2 → −1; DIVU a=100 b=7 → 14; REMU → 2.
- Special cases, all latency 1:
  - DIVU a=5 b=0 → all ones.
  - REM a=5 b=0 → 5.
  - DIV a=0x8000_0000_0000_0000 b=−1 → 0x8000_0000_0000_0000.
  - REM on the same operands → 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → res and out_valid stable, in_ready=0; raise out_ready → IDLE next edge, in_ready=1.
- Abort cases:
  - flush during BUSY at step 20 → IDLE next edge, out_valid never asserted; a following ADD 3+4 → 7.
  - rst_n pulsed low mid-BUSY → out_valid=0, res=0 immediately.
